// File: rtl/des_pkg.sv
// DES constant tables, mode/state encodings and the permutation/round helpers
// shared by the core and its per-lane round logic.
package des_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ROUND  = 2'd1;
  localparam state_t ST_OUTPUT = 2'd2;

  // Tables use 1-based DES bit numbers, bit 1 being the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed by {row, col} = {b5, b0, b4..b1} of the 6-bit S-box input.
  localparam int SBOX_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  c;
    e = '0;
    s = '0;
    p = '0;
    for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[i])];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      c = e[6'(47 - 6 * b) -: 6];
      s[5'(31 - 4 * b) -: 4] = 4'(SBOX_T[b][{c[5], c[0], c[4:1]}]);
    end
    for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
    return p;
  endfunction

endpackage

// File: rtl/des_core_pipe_round.sv
// One combinational DES Feistel round; the core chains these per clock.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] k,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);
  assign l_out = r_in;
  assign r_out = l_in ^ feistel_f(r_in, k);
endmodule

// File: rtl/des_core_pipe.sv
// Iterative DES engine, ROUNDS_PER_CYCLE rounds per clock, subkeys fetched per cycle.
// Define DES_CBC_EN to add IV/chain ports and CBC chaining; default build is ECB only.
module des_core_pipe
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CTR_W            = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [63:0]                   in_data,
`ifdef DES_CBC_EN
  input  logic [63:0]                   iv,
  input  logic                          iv_load,
  input  logic                          in_chain,
`endif
  output logic                          subkey_req,
  output logic [3:0]                    subkey_idx,
  input  logic [48*ROUNDS_PER_CYCLE-1:0] subkeys,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [63:0]                   out_data,
  output logic                          out_mode,
  output logic [CTR_W-1:0]              round_counter,
  output logic                          busy
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rpc
    $error("des_core_pipe: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t             state;
  logic [31:0]        l_r, r_r;
  logic               mode_r;
  logic [R:0][31:0]   lc, rc;
  logic [CTR_W-1:0]   rc_next;
  logic               last;
  logic [63:0]        ip_src, fp_res;

  assign in_ready   = (state == ST_IDLE);
  assign busy       = ~in_ready;
  assign subkey_req = (state == ST_ROUND);
  assign subkey_idx = (mode_r == MODE_DEC) ? 4'd15 - round_counter[3:0] : round_counter[3:0];
  assign rc_next    = round_counter + CTR_W'(R);
  assign last       = (rc_next == CTR_W'(16));

  assign lc[0] = l_r;
  assign rc[0] = r_r;
  for (genvar g = 0; g < R; g++) begin : g_lane
    des_round u_rnd (
      .l_in  (lc[g]),
      .r_in  (rc[g]),
      .k     (subkeys[48*g +: 48]),
      .l_out (lc[g+1]),
      .r_out (rc[g+1])
    );
  end

`ifdef DES_CBC_EN
  logic [63:0] chain, chain_eff, ct_r;
  logic        chain_en;
  // A same-cycle IV load wins over the old chain value for the block being accepted.
  assign chain_eff = iv_load ? iv : chain;
`endif

  always_comb begin
    ip_src = in_data;
    fp_res = fp({rc[R], lc[R]});
`ifdef DES_CBC_EN
    if (in_chain && in_mode == MODE_ENC) ip_src = in_data ^ chain_eff;
    if (chain_en && mode_r == MODE_DEC)  fp_res = fp_res ^ chain;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      l_r           <= '0;
      r_r           <= '0;
      mode_r        <= MODE_ENC;
      round_counter <= '0;
      out_data      <= '0;
      out_mode      <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          {l_r, r_r}    <= ip(ip_src);
          mode_r        <= in_mode;
          round_counter <= '0;
          state         <= ST_ROUND;
        end
        ST_ROUND: begin
          l_r           <= lc[R];
          r_r           <= rc[R];
          round_counter <= rc_next;
          if (last) begin
            out_data  <= fp_res;
            out_mode  <= mode_r;
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DES_CBC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chain    <= '0;
      ct_r     <= '0;
      chain_en <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (iv_load) chain <= iv;
      if (in_valid) begin
        ct_r     <= in_data;
        chain_en <= in_chain;
      end
    end else if (state == ST_ROUND && last && chain_en) begin
      chain <= (mode_r == MODE_ENC) ? fp_res : ct_r;
    end
  end
`endif

endmodule

// File: tb/tb_des_core_pipe.sv
// Directed bench: three cores (1, 4 and 16 rounds/clock) fed by a DES key-schedule model.
module tb_des_core_pipe;
  localparam int ND = 3;
  localparam int RPC [ND] = '{1, 4, 16};
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_B  = 64'h8787878787878787;

  localparam int PC1 [56] = '{
    57,49,41,33,25,17, 9,  1,58,50,42,34,26,18, 10, 2,59,51,43,35,27,
    19,11, 3,60,52,44,36, 63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
  localparam int PC2 [48] = '{
    14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHF [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid [ND];
  logic        in_ready [ND];
  logic        in_mode  [ND];
  logic [63:0] in_data  [ND];
  logic        subkey_req [ND];
  logic [3:0]  subkey_idx [ND];
  logic [767:0] sk_bus  [ND];
  logic        out_valid [ND];
  logic        out_ready [ND];
  logic [63:0] out_data [ND];
  logic        out_mode [ND];
  logic [4:0]  round_counter [ND];
  logic        busy [ND];
  logic        ks_mode [ND];
`ifdef DES_CBC_EN
  logic [63:0] iv [ND];
  logic        iv_load [ND];
  logic        in_chain [ND];
`endif
  logic [47:0] rk [16];
  logic [3:0]  idx_q [$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    des_core_pipe #(.ROUNDS_PER_CYCLE(RPC[g]), .CTR_W(5)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .in_mode       (in_mode[g]),
      .in_data       (in_data[g]),
`ifdef DES_CBC_EN
      .iv            (iv[g]),
      .iv_load       (iv_load[g]),
      .in_chain      (in_chain[g]),
`endif
      .subkey_req    (subkey_req[g]),
      .subkey_idx    (subkey_idx[g]),
      .subkeys       (sk_bus[g][48*RPC[g]-1:0]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready[g]),
      .out_data      (out_data[g]),
      .out_mode      (out_mode[g]),
      .round_counter (round_counter[g]),
      .busy          (busy[g])
    );
  end

  // Key-schedule model: lane l gets round idx+l (encrypt) or idx-l (decrypt).
  always_comb begin
    for (int g = 0; g < ND; g++) begin
      sk_bus[g] = '0;
      for (int l = 0; l < 16; l++)
        sk_bus[g][48*l +: 48] = rk[ks_mode[g] ? 4'(subkey_idx[g] - 4'(l)) : 4'(subkey_idx[g] + 4'(l))];
    end
  end

  task automatic set_key(input logic [63:0] key);
    logic [55:0] k56;
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] k48;
    k56 = '0;
    k48 = '0;
    for (int i = 0; i < 56; i++) k56[6'(55 - i)] = key[6'(64 - PC1[i])];
    c = k56[55:28];
    d = k56[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHF[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k48[6'(47 - i)] = cd[6'(56 - PC2[i])];
      rk[r] = k48;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_blk(input int g, input logic mode, input logic [63:0] din);
    int t;
    t = 0;
    while (!in_ready[g] && t < 50) begin
      step();
      t++;
    end
    chk("accept_ready", 64'(in_ready[g]), 64'd1);
    in_valid[g] = 1'b1;
    in_mode[g]  = mode;
    in_data[g]  = din;
    ks_mode[g]  = mode;
    step();
    in_valid[g] = 1'b0;
  endtask

  // Latency counts clock edges with the accepting edge as the first.
  task automatic wait_out(input int g, output int lat);
    lat = 1;
    idx_q.delete();
    while (!out_valid[g] && lat < 40) begin
      if (subkey_req[g]) idx_q.push_back(subkey_idx[g]);
      step();
      lat++;
    end
    chk("out_timeout", 64'(out_valid[g]), 64'd1);
  endtask

  task automatic pop_out(input int g);
    out_ready[g] = 1'b1;
    step();
    out_ready[g] = 1'b0;
    chk("pop_valid", 64'(out_valid[g]), 64'd0);
    chk("pop_ready", 64'(in_ready[g]), 64'd1);
  endtask

  task automatic run_ecb(input int g, input logic mode, input logic [63:0] din,
                         input logic [63:0] exp, input int exp_lat, input string tag);
    int lat;
    accept_blk(g, mode, din);
    wait_out(g, lat);
    chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, out_data[g], exp);
    chk({tag, "_mode"}, 64'(out_mode[g]), 64'(mode));
    chk({tag, "_rc"},   64'(round_counter[g]), 64'd16);
    pop_out(g);
  endtask

  initial begin
    int          lat;
    int          bad;
    logic [63:0] seq;
`ifdef DES_CBC_EN
    logic [63:0] c1, c2;
`endif
    for (int g = 0; g < ND; g++) begin
      in_valid[g] = 1'b0; in_mode[g] = 1'b0; in_data[g] = '0;
      out_ready[g] = 1'b0; ks_mode[g] = 1'b0;
`ifdef DES_CBC_EN
      iv[g] = '0; iv_load[g] = 1'b0; in_chain[g] = 1'b0;
`endif
    end
    set_key(KEY_A);

    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_rc",        64'(round_counter[0]), 64'd0);
    chk("rst_out_data",  out_data[0], 64'd0);
    chk("rst_in_ready",  64'(in_ready[0]), 64'd1);
    chk("rst_busy",      64'(busy[0]), 64'd0);
    chk("rst_skreq",     64'(subkey_req[0]), 64'd0);
    rst = 1'b0;
    step();

    // out_ready with nothing to deliver must not move the engine
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    chk("idle_oready_valid", 64'(out_valid[0]), 64'd0);
    chk("idle_oready_ready", 64'(in_ready[0]), 64'd1);

    // R=1 encrypt, with the full subkey index walk
    accept_blk(0, 1'b0, PT_A);
    chk("enc1_busy", 64'(busy[0]), 64'd1);
    wait_out(0, lat);
    chk("enc1_lat",  64'(lat), 64'd17);
    chk("enc1_data", out_data[0], CT_A);
    chk("enc1_mode", 64'(out_mode[0]), 64'd0);
    chk("enc1_rc",   64'(round_counter[0]), 64'd16);
    seq = '0;
    foreach (idx_q[i]) seq = {seq[59:0], idx_q[i]};
    chk("enc1_idx_n",   64'(idx_q.size()), 64'd16);
    chk("enc1_idx_seq", seq, 64'h0123456789ABCDEF);
    pop_out(0);

    // R=4 decrypt, subkey indices walk down by four
    accept_blk(1, 1'b1, CT_A);
    wait_out(1, lat);
    chk("dec4_lat",  64'(lat), 64'd5);
    chk("dec4_data", out_data[1], PT_A);
    chk("dec4_mode", 64'(out_mode[1]), 64'd1);
    seq = '0;
    foreach (idx_q[i]) seq = {seq[59:0], idx_q[i]};
    chk("dec4_idx_n",   64'(idx_q.size()), 64'd4);
    chk("dec4_idx_seq", seq, 64'h000000000000FB73);
    pop_out(1);

    run_ecb(1, 1'b0, PT_A, CT_A, 5, "enc4");
    run_ecb(2, 1'b0, PT_A, CT_A, 2, "enc16");
    run_ecb(2, 1'b1, CT_A, PT_A, 2, "dec16");

    // R=16 backpressure with a second block waiting upstream
    set_key(KEY_B);
    accept_blk(2, 1'b0, PT_B);
    wait_out(2, lat);
    chk("bp_lat",  64'(lat), 64'd2);
    chk("bp_data", out_data[2], 64'd0);
    in_valid[2] = 1'b1;
    in_mode[2]  = 1'b1;
    in_data[2]  = 64'd0;
    ks_mode[2]  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_data[2] !== 64'd0 || out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0 ||
          round_counter[2] !== 5'd16 || out_mode[2] !== 1'b0) bad++;
    end
    chk("bp_hold_cycles", 64'(bad), 64'd0);
    out_ready[2] = 1'b1;
    step();
    out_ready[2] = 1'b0;
    chk("bp_pop_valid", 64'(out_valid[2]), 64'd0);
    chk("bp_pop_ready", 64'(in_ready[2]), 64'd1);
    step();
    in_valid[2] = 1'b0;
    chk("bp_2nd_busy", 64'(busy[2]), 64'd1);
    chk("bp_2nd_rc",   64'(round_counter[2]), 64'd0);
    wait_out(2, lat);
    chk("bp_2nd_lat",  64'(lat), 64'd2);
    chk("bp_2nd_data", out_data[2], PT_B);
    chk("bp_2nd_mode", 64'(out_mode[2]), 64'd1);
    pop_out(2);

    // reset in the middle of a block on the R=1 core
    set_key(KEY_A);
    accept_blk(0, 1'b0, PT_A);
    repeat (8) step();
    chk("mid_rc", 64'(round_counter[0]), 64'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 64'(in_ready[0]), 64'd1);
    chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_rc",    64'(round_counter[0]), 64'd0);
    chk("mid_rst_busy",  64'(busy[0]), 64'd0);
    run_ecb(0, 1'b0, PT_A, CT_A, 17, "post_rst");

`ifdef DES_CBC_EN
    in_chain[2] = 1'b1;
    iv[2] = 64'd0;
    iv_load[2] = 1'b1;
    step();
    iv_load[2] = 1'b0;
    accept_blk(2, 1'b0, PT_A);
    wait_out(2, lat);
    c1 = out_data[2];
    chk("cbc_c1", c1, CT_A);
    pop_out(2);
    accept_blk(2, 1'b0, PT_A);
    wait_out(2, lat);
    c2 = out_data[2];
    chk("cbc_c2_differs", 64'(c2 != c1), 64'd1);
    pop_out(2);
    // IV loaded on the accepting edge applies to that block: E(B ^ IV) with B ^ IV = PT_A
    iv[2] = 64'hFFFF_FFFF_FFFF_FFFF ^ PT_A;
    iv_load[2] = 1'b1;
    accept_blk(2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    iv_load[2] = 1'b0;
    wait_out(2, lat);
    chk("cbc_iv_same_edge", out_data[2], CT_A);
    pop_out(2);
    iv[2] = 64'd0;
    iv_load[2] = 1'b1;
    step();
    iv_load[2] = 1'b0;
    accept_blk(2, 1'b1, c1);
    wait_out(2, lat);
    chk("cbc_dec1", out_data[2], PT_A);
    pop_out(2);
    accept_blk(2, 1'b1, c2);
    wait_out(2, lat);
    chk("cbc_dec2", out_data[2], PT_A);
    pop_out(2);
    in_chain[2] = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
